// File: rtl/arithmetic_logic_unit.sv
// arithmetic_logic_unit: RV32i execute-stage ALU with registered result/branch copies.
//   CLK                 clock for the registered copies only
//   RST_N               asynchronous active-low reset of the registered copies
//   ALU_Control [3:0]   operation select
//   SrcA/SrcB  [31:0]   operands (rs1/PC, rs2/immediate)
//   Result     [31:0]   combinational result
//   Branch_Condition    combinational branch-taken flag
//   Result_Q, Branch_Condition_Q  copies registered on CLK
//   Overflow            signed ADD/SUB overflow when ALU_OVERFLOW_FLAG_EN is defined, else 0
module arithmetic_logic_unit (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  ALU_Control,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic [31:0] Result,
  output logic        Branch_Condition,
  output logic [31:0] Result_Q,
  output logic        Branch_Condition_Q,
  output logic        Overflow
);
  localparam logic [3:0] ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND  = 4'd2,  ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4,  ALU_SLL  = 4'd5,  ALU_SRL  = 4'd6,  ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_BEQ  = 4'd8,  ALU_BNE  = 4'd9,  ALU_BLT  = 4'd10, ALU_BLTU = 4'd11;
  localparam logic [3:0] ALU_BGE  = 4'd12, ALU_BGEU = 4'd13, ALU_LUI  = 4'd14;
  logic [31:0] w_sum, w_diff, w_sra;
  logic [4:0]  w_shamt;
  logic        w_eq, w_lt, w_ltu;
  assign w_sum   = SrcA + SrcB;
  assign w_diff  = SrcA - SrcB;
  assign w_shamt = SrcB[4:0];
  assign w_sra   = $signed(SrcA) >>> w_shamt;
  assign w_eq    = SrcA == SrcB;
  assign w_lt    = $signed(SrcA) < $signed(SrcB);
  assign w_ltu   = SrcA < SrcB;
  always_comb begin
    Result = 32'd0;
    case (ALU_Control)
      ALU_ADD:  Result = w_sum;
      ALU_SUB:  Result = w_diff;
      ALU_AND:  Result = SrcA & SrcB;
      ALU_OR:   Result = SrcA | SrcB;
      ALU_XOR:  Result = SrcA ^ SrcB;
      ALU_SLL:  Result = SrcA << w_shamt;
      ALU_SRL:  Result = SrcA >> w_shamt;
      ALU_SRA:  Result = w_sra;
      ALU_BLT:  Result = {31'd0, w_lt};
      ALU_BLTU: Result = {31'd0, w_ltu};
      ALU_LUI:  Result = SrcB;
      default:  Result = 32'd0;
    endcase
  end
  always_comb begin
    Branch_Condition = 1'b0;
    case (ALU_Control)
      ALU_BEQ:  Branch_Condition = w_eq;
      ALU_BNE:  Branch_Condition = !w_eq;
      ALU_BLT:  Branch_Condition = w_lt;
      ALU_BLTU: Branch_Condition = w_ltu;
      ALU_BGE:  Branch_Condition = !w_lt;
      ALU_BGEU: Branch_Condition = !w_ltu;
      default:  Branch_Condition = 1'b0;
    endcase
  end
`ifdef ALU_OVERFLOW_FLAG_EN
  // Addition overflows when like-signed operands give an opposite-signed sum;
  // subtraction when unlike-signed operands give a result whose sign leaves SrcA's.
  assign Overflow = (ALU_Control == ALU_ADD) ? (SrcA[31] == SrcB[31]) && (w_sum[31] != SrcA[31]) :
                    (ALU_Control == ALU_SUB) ? (SrcA[31] != SrcB[31]) && (w_diff[31] != SrcA[31]) : 1'b0;
`else
  assign Overflow = 1'b0;
`endif
  logic [31:0] r_result;
  logic        r_branch;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_result <= 32'd0;
      r_branch <= 1'b0;
    end else begin
      r_result <= Result;
      r_branch <= Branch_Condition;
    end
  end
  assign Result_Q           = r_result;
  assign Branch_Condition_Q = r_branch;
endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// tb_arithmetic_logic_unit: scoreboard bench for arithmetic_logic_unit against an arithmetic reference model.
module tb_arithmetic_logic_unit;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [3:0]  ALU_Control = 4'd0;
  logic [31:0] SrcA = 32'd0, SrcB = 32'd0;
  logic [31:0] Result, Result_Q;
  logic        Branch_Condition, Branch_Condition_Q, Overflow;
  int tests = 0, fails = 0;
  typedef struct packed {logic [31:0] r; logic c; logic o; logic [3:0] op; logic [31:0] a; logic [31:0] b;} exp_t;
  exp_t q[$];
  arithmetic_logic_unit dut (
    .CLK(CLK), .RST_N(RST_N), .ALU_Control(ALU_Control), .SrcA(SrcA), .SrcB(SrcB),
    .Result(Result), .Branch_Condition(Branch_Condition), .Result_Q(Result_Q),
    .Branch_Condition_Q(Branch_Condition_Q), .Overflow(Overflow)
  );
  always #5 CLK = ~CLK;
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = {32'd0, a};
    longint ub = {32'd0, b};
    longint p  = longint'(1) << b[4:0];
    longint s  = 0;
    exp_t e = '0;
    e.op = op; e.a = a; e.b = b;
    case (op)
      4'd0: begin s = sa + sb; e.r = 32'(s); e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd1: begin s = sa - sb; e.r = 32'(s); e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd2: e.r = a & b;
      4'd3: e.r = a | b;
      4'd4: e.r = a ^ b;
      4'd5: e.r = 32'(ua * p);
      4'd6: e.r = 32'(ua / p);
      4'd7: e.r = 32'((sa >= 0) ? sa / p : -((-sa + p - 1) / p));
      4'd8: e.c = (ua == ub);
      4'd9: e.c = (ua != ub);
      4'd10: begin e.c = sa < sb; e.r = {31'd0, e.c}; end
      4'd11: begin e.c = ua < ub; e.r = {31'd0, e.c}; end
      4'd12: e.c = sa >= sb;
      4'd13: e.c = ua >= ub;
      4'd14: e.r = b;
      default: e.r = 32'd0;
    endcase
`ifndef ALU_OVERFLOW_FLAG_EN
    e.o = 1'b0;
`endif
    return e;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input exp_t e);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s op=%0d a=%h b=%h got=%h expected=%h", name, e.op, e.a, e.b, act, exp);
    end
  endtask
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    ALU_Control = op; SrcA = a; SrcB = b;
    q.push_back(model(op, a, b));
  endtask
  always begin
    @(posedge CLK);
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("result",   Result,                     e.r,           e);
      chk("cond",     {31'd0, Branch_Condition},   {31'd0, e.c},  e);
      chk("overflow", {31'd0, Overflow},           {31'd0, e.o},  e);
      chk("result_q", Result_Q,                   e.r,           e);
      chk("cond_q",   {31'd0, Branch_Condition_Q}, {31'd0, e.c},  e);
    end
  end
  function automatic logic [31:0] pick();
    logic [31:0] c [5] = '{32'd0, 32'd1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    return ($urandom_range(0, 3) == 0) ? c[$urandom_range(0, 4)] : $urandom;
  endfunction
  exp_t none;
  initial begin
    none = '0;
    #3;
    chk("rst_result_q", Result_Q, 32'd0, none);
    chk("rst_cond_q", {31'd0, Branch_Condition_Q}, 32'd0, none);
    @(negedge CLK);
    RST_N = 1'b1;
    issue(0, 1, 1);                   issue(0, 32'h7FFFFFFF, 1);
    issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF); issue(1, 32'h80000000, 1);
    issue(1, 1, 1);
    issue(2, 0, 32'hFFFFFFFF);        issue(2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(3, 0, 32'hFFFFFFFF);        issue(3, 32'hFFFFFFFF, 32'hFFFFFFFF); issue(3, 0, 0);
    issue(4, 0, 32'hFFFFFFFF);        issue(4, 32'hFFFFFFFF, 32'hFFFFFFFF); issue(4, 0, 0);
    issue(5, 32'hF0F0F0F0, 4);        issue(5, 1, 2);
    issue(6, 32'hF0F0F0F0, 4);        issue(6, 32'h10, 1);
    issue(5, 1, 1);                   issue(6, 2, 1);
    issue(7, 32'hFFFFFFFF, 32'h7FFFFFFF); issue(7, 32'h80000000, 4);
    issue(8, 5, 5);  issue(8, 5, 6);  issue(9, 5, 6);  issue(9, 5, 5);
    issue(10, 32'hFFFFFFFF, 0);       issue(10, 0, 0);
    issue(11, 0, 32'hFFFFFFFF);       issue(11, 32'hFFFFFFFF, 0);
    issue(12, 0, 32'hFFFFFFFF);       issue(12, 0, 1);
    issue(13, 32'hFFFFFFFF, 0);       issue(13, 0, 32'hFFFFFFFF);
    issue(14, 0, 32'hFFFFFFFF);       issue(14, 0, 32'hF0F0F0F0);
    issue(15, 32'hFFFFFFFF, 32'h12345678);
    for (int i = 0; i < 400; i++) issue(4'($urandom_range(0, 15)), pick(), pick());
    issue(0, 7, 9);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst_result_q", Result_Q, 32'd0, none);
    chk("async_rst_cond_q", {31'd0, Branch_Condition_Q}, 32'd0, none);
    @(posedge CLK);
    #1;
    chk("held_rst_result_q", Result_Q, 32'd0, none);
    @(negedge CLK);
    RST_N = 1'b1;
    issue(0, 2, 3);
    issue(8, 32'hABCD0123, 32'hABCD0123);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
    #2;
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
